// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding instruction-memory request feeding a
// single-entry decode buffer, with branch/jump redirect at any point of a fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_inst,
  output logic [5:0]  o_if_opcode,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc_plus4,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending_pc;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [31:0] w_target;
  logic        w_xfer;

  assign w_target = {i_redirect_pc[31:2], 2'b00};
  assign w_xfer   = (r_state == HOLD) && i_if_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT: w_next_state = FETCH;
      FETCH: begin
        if (i_imem_ack) begin
          w_next_state = i_redirect_en ? FETCH : HOLD;
        end else if (i_redirect_en) begin
          w_next_state = DISCARD;
        end
      end
      HOLD: begin
        if (i_redirect_en || w_xfer) begin
          w_next_state = FETCH;
        end
      end
      DISCARD: begin
        if (i_imem_ack) begin
          w_next_state = FETCH;
        end
      end
      default: w_next_state = BOOT;
    endcase
  end

  always_comb begin
    o_imem_req = 1'b0;
    o_if_valid = 1'b0;
    case (r_state)
      FETCH:   o_imem_req = 1'b1;
      DISCARD: o_imem_req = 1'b1;
      HOLD:    o_if_valid = 1'b1;
      default: begin
        o_imem_req = 1'b0;
        o_if_valid = 1'b0;
      end
    endcase
  end

  // pc only moves when no request is in flight or the in-flight one completes,
  // so imem_addr stays stable for the whole life of a request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc         <= RESET_PC;
      r_pending_pc <= 32'h0000_0000;
      r_if_inst    <= 32'h0000_0000;
      r_if_pc      <= 32'h0000_0000;
    end else begin
      case (r_state)
        FETCH: begin
          if (i_imem_ack) begin
            if (i_redirect_en) begin
              r_pc <= w_target;
            end else begin
              r_if_inst <= i_imem_rdata;
              r_if_pc   <= r_pc;
              r_pc      <= r_pc + 32'd4;
            end
          end else if (i_redirect_en) begin
            r_pending_pc <= w_target;
          end
        end
        HOLD: begin
          if (i_redirect_en) begin
            r_pc <= w_target;
          end
        end
        DISCARD: begin
          if (i_redirect_en) begin
            r_pending_pc <= w_target;
          end
          if (i_imem_ack) begin
            r_pc <= i_redirect_en ? w_target : r_pending_pc;
          end
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_if_inst     = r_if_inst;
  assign o_if_opcode   = r_if_inst[31:26];
  assign o_if_pc       = r_if_pc;
  assign o_if_pc_plus4 = r_if_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory latency, decode back-pressure and
// redirects, checked by an in-order scoreboard of expected fetch addresses.
module tb_instr_fetch_unit;

  localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        redirect_en;
  logic [31:0] redirect_pc;

  logic        req_w;
  logic [31:0] addr_w;
  logic        ack_w;
  logic [31:0] rdata_w;
  logic        valid_w;
  logic        ready_w;
  logic [31:0] inst_w;
  logic [5:0]  opcode_w;
  logic [31:0] pc_w;
  logic [31:0] plus4_w;
  logic        redir_en_w;
  logic [31:0] redir_pc_w;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];

  bit resp_on    = 1'b1;
  bit stale_ack  = 1'b0;
  int resp_lat   = 2;
  int resp_cnt   = 0;

  instr_fetch_unit #(.RESET_PC(MAIN_RESET_PC)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_if_valid(if_valid), .i_if_ready(if_ready),
    .o_if_inst(if_inst), .o_if_opcode(if_opcode),
    .o_if_pc(if_pc), .o_if_pc_plus4(if_pc_plus4),
    .i_redirect_en(redirect_en), .i_redirect_pc(redirect_pc)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_RESET_PC)) dut_w (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(req_w), .o_imem_addr(addr_w),
    .i_imem_ack(ack_w), .i_imem_rdata(rdata_w),
    .o_if_valid(valid_w), .i_if_ready(ready_w),
    .o_if_inst(inst_w), .o_if_opcode(opcode_w),
    .o_if_pc(pc_w), .o_if_pc_plus4(plus4_w),
    .i_redirect_en(redir_en_w), .i_redirect_pc(redir_pc_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int pick_lat();
    if (resp_lat < 0) return int'($urandom_range(0, 3));
    return resp_lat;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    redirect_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Memory responder: acks a live request after a chosen number of cycles.
  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_on) begin
        imem_ack = stale_ack;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        resp_cnt = pick_lat();
      end else if (imem_req) begin
        if (resp_cnt <= 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end else begin
          resp_cnt--;
        end
      end else begin
        resp_cnt = pick_lat();
      end
    end
  end

  // Monitor: protocol invariants plus the in-order scoreboard. The expected
  // stream is sequential words from the last redirect target (or reset pc).
  initial begin
    logic        p_stall, p_req, p_ack;
    logic [31:0] p_inst, p_pc, p_addr, e;
    p_stall = 0; p_req = 0; p_ack = 0; p_inst = 0; p_pc = 0; p_addr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(MAIN_RESET_PC);
        p_stall = 0; p_req = 0; p_ack = 0;
      end else begin
        chk("pc_plus4", if_pc_plus4, if_pc + 32'd4);
        if (if_valid) begin
          chk("opcode", {26'h0, if_opcode}, {26'h0, if_inst[31:26]});
          chk("no_req_while_valid", {31'h0, imem_req}, 32'h0);
        end
        if (p_stall) begin
          chk("stall_valid", {31'h0, if_valid}, 32'h1);
          chk("stall_inst", if_inst, p_inst);
          chk("stall_pc", if_pc, p_pc);
        end
        if (p_req && !p_ack) begin
          chk("req_held", {31'h0, imem_req}, 32'h1);
          chk("addr_stable", imem_addr, p_addr);
        end
        if (imem_req && (!p_req || p_ack)) req_log.push_back(imem_addr);
        if (if_valid && if_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_xfer", if_pc, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", if_pc, e);
            chk("sb_inst", if_inst, mem_word(e));
            if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
          end
        end
        if (redirect_en) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc & ~32'h3);
        end
        p_stall = if_valid && !if_ready && !redirect_en;
        p_inst  = if_inst;
        p_pc    = if_pc;
        p_req   = imem_req;
        p_ack   = imem_ack;
        p_addr  = imem_addr;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int xb;
    rst = 1'b1; if_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    ack_w = 1'b0; rdata_w = 32'h0; ready_w = 1'b0; redir_en_w = 1'b0; redir_pc_w = 32'h0;

    // Sequential fetch, fixed memory latency, decode always ready
    reset_dut();
    req_log.delete();
    chk("rst_release_valid", {31'h0, if_valid}, 32'h0);
    resp_lat = 2; if_ready = 1'b1;
    for (k = 0; k < 20 && !imem_ack; k++) tick();
    chk("a_ack_seen", {31'h0, imem_ack}, 32'h1);
    tick();
    chk("a_latency_valid", {31'h0, if_valid}, 32'h1);
    chk("a_first_inst", if_inst, mem_word(32'h0));
    repeat (20) tick();
    chk("a_addr0", req_log[0], 32'h0);
    chk("a_addr1", req_log[1], 32'h4);
    chk("a_addr2", req_log[2], 32'h8);

    // Wrapping reset pc on the second instance
    reset_dut();
    tick();
    chk("w_req", {31'h0, req_w}, 32'h1);
    chk("w_addr", addr_w, 32'hFFFF_FFFC);
    ack_w = 1'b1; rdata_w = 32'h1234_5678;
    tick();
    ack_w = 1'b0;
    chk("w_valid", {31'h0, valid_w}, 32'h1);
    chk("w_if_pc", pc_w, 32'hFFFF_FFFC);
    chk("w_plus4", plus4_w, 32'h0);
    chk("w_inst", inst_w, 32'h1234_5678);
    ready_w = 1'b1;
    tick();
    ready_w = 1'b0;
    chk("w_next_req", {31'h0, req_w}, 32'h1);
    chk("w_next_addr", addr_w, 32'h0);

    // Decode stall with a held instruction
    reset_dut();
    if_ready = 1'b0; resp_lat = 2;
    for (k = 0; k < 20 && !if_valid; k++) tick();
    chk("b_valid", {31'h0, if_valid}, 32'h1);
    chk("b_inst", if_inst, 32'h8C22_0004);
    chk("b_opcode", {26'h0, if_opcode}, 32'h23);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_hold_valid", {31'h0, if_valid}, 32'h1);
      chk("b_hold_inst", if_inst, 32'h8C22_0004);
      chk("b_hold_pc", if_pc, 32'h0);
      chk("b_hold_noreq", {31'h0, imem_req}, 32'h0);
    end
    if_ready = 1'b1;
    repeat (10) tick();

    // Redirect while the request for 0x8 is outstanding
    reset_dut();
    if_ready = 1'b1; resp_lat = 5;
    for (k = 0; k < 80 && !(imem_req && imem_addr == 32'h8 && !imem_ack); k++) tick();
    chk("c_req8_seen", imem_addr, 32'h8);
    redirect_en = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_en = 1'b0;
    for (k = 0; k < 20 && !imem_ack; k++) begin
      chk("c_addr_held", imem_addr, 32'h8);
      tick();
    end
    chk("c_ack_seen", {31'h0, imem_ack}, 32'h1);
    tick();
    chk("c_new_req", {31'h0, imem_req}, 32'h1);
    chk("c_new_addr", imem_addr, 32'h100);
    repeat (20) tick();

    // Redirect in HOLD together with a transfer
    reset_dut();
    if_ready = 1'b0; resp_lat = 1;
    for (k = 0; k < 20 && !if_valid; k++) tick();
    chk("d_valid", {31'h0, if_valid}, 32'h1);
    xb = n_xfer;
    if_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_en = 1'b0;
    chk("d_accepted_once", n_xfer, xb + 1);
    chk("d_valid_dropped", {31'h0, if_valid}, 32'h0);
    chk("d_req", {31'h0, imem_req}, 32'h1);
    chk("d_addr", imem_addr, 32'h40);
    repeat (10) tick();

    // Reset during DISCARD, then a stale ack in BOOT
    reset_dut();
    if_ready = 1'b1; resp_lat = 5;
    tick(); tick();
    redirect_en = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0;
    tick();
    chk("e_in_discard_req", {31'h0, imem_req}, 32'h1);
    resp_on = 1'b0; stale_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("e_rst_req", {31'h0, imem_req}, 32'h0);
    chk("e_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("e_rst_inst", if_inst, 32'h0);
    chk("e_rst_pc", if_pc, 32'h0);
    chk("e_rst_addr", imem_addr, MAIN_RESET_PC);
    tick();
    stale_ack = 1'b1;
    tick();
    rst = 1'b0;
    stale_ack = 1'b0;
    tick();
    chk("e_boot_exit_req", {31'h0, imem_req}, 32'h1);
    chk("e_boot_exit_addr", imem_addr, MAIN_RESET_PC);
    chk("e_boot_exit_valid", {31'h0, if_valid}, 32'h0);
    resp_on = 1'b1;
    xb = n_xfer;
    repeat (20) tick();
    chk("e_restart_progress", {31'h0, n_xfer > xb}, 32'h1);

    // Randomized traffic
    reset_dut();
    resp_lat = -1;
    tick();
    xb = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      tick();
      redirect_en = 1'b0;
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect_en = 1'b1;
        if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else redirect_pc = $urandom;
      end
    end
    redirect_en = 1'b0;
    tick();
    chk("f_progress", {31'h0, (n_xfer - xb) > 200}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000; first fetch address after reset, word aligned.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory request; held high until imem_ack.
REQ-005 imem_addr  output  32  fetch address; stable while imem_req is high.
REQ-006 imem_ack  input  1  one-cycle response strobe; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 if_valid  output  1  buffered instruction available to decode.
REQ-009 if_ready  input  1  decode accepts; transfer occurs when if_valid and if_ready are both high.
REQ-010 if_inst  output  32  buffered instruction word.
REQ-011 if_opcode  output  6  if_inst[31:26]; feeds the control-unit opcode input.
REQ-012 if_pc  output  32  address of if_inst.
REQ-013 if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
REQ-014 redirect_en  input  1  branch/jump taken; one-cycle pulse.
REQ-015 redirect_pc  input  32  new fetch target; bits [1:0] ignored and treated as 0.

Function
REQ-016 The FSM SHALL have the states BOOT, FETCH, HOLD and DISCARD.
REQ-017 BOOT SHALL go unconditionally to FETCH on the first clock edge after reset deasserts.
REQ-018 imem_req SHALL be high in FETCH and DISCARD only, and imem_addr SHALL equal the internal pc register.
REQ-019 In FETCH with imem_ack and no redirect, the block SHALL capture imem_rdata into if_inst, capture pc into if_pc, advance pc to pc+4, and go to HOLD.
REQ-020 if_valid SHALL be high exactly in HOLD.
REQ-021 In HOLD with a transfer and no redirect, the block SHALL go to FETCH on the next edge.
REQ-022 In HOLD without if_ready, if_inst, if_pc and if_valid SHALL hold unchanged for any number of cycles.
REQ-023 Latency SHALL be one cycle from imem_ack to if_valid high; the block SHALL have at most one outstanding request and one buffered instruction.
REQ-024 A redirect in HOLD SHALL set pc to {redirect_pc[31:2],2'b00}, drop the buffer (if_valid low next cycle), and go to FETCH; a transfer in the same cycle still counts as accepted.
REQ-025 A redirect in FETCH without imem_ack SHALL store the target in pending_pc and go to DISCARD; imem_req and imem_addr SHALL stay unchanged until ack.
REQ-026 A redirect in FETCH coinciding with imem_ack SHALL discard imem_rdata, load pc with the target, and stay in FETCH.
REQ-027 In DISCARD, imem_ack SHALL discard the data, load pc from pending_pc, and go to FETCH.
REQ-028 A further redirect in DISCARD SHALL overwrite pending_pc; if it coincides with imem_ack, the new redirect_pc SHALL be used.
REQ-029 The pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000), and the same wrap SHALL apply to if_pc_plus4.
REQ-030 imem_ack outside FETCH or DISCARD SHALL be ignored.

Reset
REQ-031 While rst is high: state = BOOT, pc = RESET_PC, pending_pc = 0, if_inst = 0, if_pc = 0, imem_req = 0, if_valid = 0.
REQ-032 Assertion of rst mid-request or mid-hold SHALL abandon the operation immediately, with no wait for imem_ack.

Verification
REQ-033 Reset release, memory acks 2 cycles after each req, if_ready tied high -> imem_addr sequence 0x0, 0x4, 0x8; if_inst matches memory; if_opcode = if_inst[31:26].
REQ-034 if_ready low for 5 cycles in HOLD with if_inst = 0x8C220004 -> if_valid, if_inst and if_pc stable; no imem_req until the transfer.
REQ-035 Redirect to 0x103 while the request for 0x8 is outstanding -> imem_addr stays 0x8 until ack; that data is not presented; next imem_addr = 0x100.
REQ-036 Redirect to 0x40 in HOLD at the same cycle as a transfer -> the word is accepted once; if_valid low next cycle; next imem_addr = 0x40.
REQ-037 RESET_PC = 0xFFFFFFFC -> first if_pc = 0xFFFFFFFC, if_pc_plus4 = 0x0, next imem_addr = 0x0.
REQ-038 rst pulsed while in DISCARD -> all outputs at reset values; fetch restarts at RESET_PC; a stale imem_ack is ignored in BOOT.
